// File: rtl/mem_access_if.sv
// mem_access_if: datapath load/store request signals plus the req/ack data-memory port.
interface mem_access_if;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memDataSize;
  logic        memBitExt;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        stall;
  logic        accessErr;
  logic        busErr;
  logic        dmReq;
  logic        dmWe;
  logic [31:0] dmAddr;
  logic [3:0]  dmBe;
  logic [31:0] dmWdata;
  logic [31:0] dmRdata;
  logic        dmAck;
  modport master (
    output memRead, memWrite, memDataSize, memBitExt, addr, wrData, dmRdata, dmAck,
    input  rdData, stall, accessErr, busErr, dmReq, dmWe, dmAddr, dmBe, dmWdata
  );
  modport slave (
    input  memRead, memWrite, memDataSize, memBitExt, addr, wrData, dmRdata, dmAck,
    output rdData, stall, accessErr, busErr, dmReq, dmWe, dmAddr, dmBe, dmWdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage driving a req/ack data memory, with stall, extension and error flags.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rd_q, rd_d, addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [1:0]    size_q, size_d, off_q, off_d;
  logic          req_q, req_d, we_q, we_d, ext_q, ext_d;
  logic          acc_err_q, acc_err_d, bus_err_q, bus_err_d;
  logic          acc, ill;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new, load;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  assign acc = bus.memRead | bus.memWrite;
  assign ill = (bus.memDataSize == 2'd3) | ((bus.memDataSize == 2'd0) & (bus.addr[1:0] != 2'b00))
             | ((bus.memDataSize == 2'd1) & bus.addr[0]) | (bus.memRead & bus.memWrite);
  assign be_new = (bus.memDataSize == 2'd0) ? 4'b1111
                : (bus.memDataSize == 2'd1) ? (bus.addr[1] ? 4'b1100 : 4'b0011)
                : 4'b0001 << bus.addr[1:0];
  assign wdata_new = (bus.memDataSize == 2'd0) ? bus.wrData
                   : (bus.memDataSize == 2'd1) ? {2{bus.wrData[15:0]}}
                   : {4{bus.wrData[7:0]}};
  // Lane selection and extension use the copies latched at request time.
  assign lane_b = bus.dmRdata[{off_q, 3'b000} +: 8];
  assign lane_h = bus.dmRdata[{off_q[1], 4'b0000} +: 16];
  assign load = (size_q == 2'd2) ? {{24{~ext_q & lane_b[7]}}, lane_b}
              : (size_q == 2'd1) ? {{16{~ext_q & lane_h[15]}}, lane_h}
              : bus.dmRdata;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    ext_d     = ext_q;
    off_d     = off_q;
    acc_err_d = 1'b0;
    bus_err_d = 1'b0;
    if (state_q == IDLE && acc && ill) begin
      acc_err_d = 1'b1;
    end else if (state_q == IDLE && acc) begin
      addr_d  = {bus.addr[31:2], 2'b00};
      we_d    = bus.memWrite;
      be_d    = be_new;
      wdata_d = wdata_new;
      size_d  = bus.memDataSize;
      ext_d   = bus.memBitExt;
      off_d   = bus.addr[1:0];
      req_d   = 1'b1;
      cnt_d   = '0;
      state_d = WAIT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + CW'(1);
      if (bus.dmAck) begin
        req_d   = 1'b0;
        rd_d    = we_q ? rd_q : load;
        cnt_d   = '0;
        state_d = DONE;
      end else if (cnt_q == LAST) begin
        req_d     = 1'b0;
        bus_err_d = 1'b1;
        rd_d      = we_q ? rd_q : '0;
        cnt_d     = '0;
        state_d   = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_q      <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      ext_q     <= 1'b0;
      off_q     <= '0;
      acc_err_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      ext_q     <= ext_d;
      off_q     <= off_d;
      acc_err_q <= acc_err_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus.stall     = (state_q == IDLE && acc && !ill) || state_q == WAIT;
  assign bus.rdData    = rd_q;
  assign bus.accessErr = acc_err_q;
  assign bus.busErr    = bus_err_q;
  assign bus.dmReq     = req_q;
  assign bus.dmWe      = we_q;
  assign bus.dmAddr    = addr_q;
  assign bus.dmBe      = be_q;
  assign bus.dmWdata   = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven load/store vectors plus sequences for ack delay, timeout and reset.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mem_access_if bus();
  mem_access_unit #(.TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic rd; logic wr; logic [1:0] sz; logic ext;
    logic [31:0] a; logic [31:0] wd; logic [31:0] rdat; logic ill;
    logic [3:0] be; logic [31:0] da; logic [31:0] dw; logic [31:0] rv;
  } vec_t;
  vec_t v[13];
  int total = 0;
  int bad = 0;
  logic [31:0] last_rd = 32'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic idle_inputs();
    bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.memDataSize = 2'd0; bus.memBitExt = 1'b0;
    bus.addr = 32'h0; bus.wrData = 32'h0; bus.dmAck = 1'b0; bus.dmRdata = 32'h0;
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic ext,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.memRead = rd; bus.memWrite = wr; bus.memDataSize = sz; bus.memBitExt = ext;
    bus.addr = a; bus.wrData = wd;
  endtask
  initial begin
    int st, waits;
    logic seen;
    v[0]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h103, 32'h0,        32'h80112233, 1'b0, 4'b1000, 32'h100, 32'h0,        32'hFFFFFF80};
    v[1]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h103, 32'h0,        32'h80112233, 1'b0, 4'b1000, 32'h100, 32'h0,        32'h00000080};
    v[2]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        32'h80015555, 1'b0, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001};
    v[3]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h100, 32'h0,        32'h12348765, 1'b0, 4'b0011, 32'h100, 32'h0,        32'h00008765};
    v[4]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h104, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h104, 32'h0,        32'hDEADBEEF};
    v[5]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h101, 32'h0,        32'h80112233, 1'b0, 4'b0010, 32'h100, 32'h0,        32'h00000022};
    v[6]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'h0,        1'b0, 4'b1100, 32'h100, 32'hABCDABCD, 32'h0};
    v[7]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h203, 32'h000000A5, 32'h0,        1'b0, 4'b1000, 32'h200, 32'hA5A5A5A5, 32'h0};
    v[8]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0,        1'b0, 4'b1111, 32'h300, 32'hCAFEF00D, 32'h0};
    v[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0,    32'h0,   32'h0,        32'h0};
    v[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0,    32'h0,   32'h0,        32'h0};
    v[11] = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 4'b0,    32'h0,   32'h0,        32'h0};
    v[12] = '{1'b1, 1'b1, 2'd0, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 4'b0,    32'h0,   32'h0,        32'h0};
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("reset_rdData", bus.rdData, 32'h0);
    chk("reset_dmReq", {31'h0, bus.dmReq}, 32'h0);
    chk("reset_dmBe", {28'h0, bus.dmBe}, 32'h0);
    chk("reset_flags", {29'h0, bus.stall, bus.accessErr, bus.busErr}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      drive(v[i].rd, v[i].wr, v[i].sz, v[i].ext, v[i].a, v[i].wd);
      #1;
      chk($sformatf("v%0d_stall_req", i), {31'h0, bus.stall}, {31'h0, ~v[i].ill});
      @(negedge clk);
      if (v[i].ill) begin
        chk($sformatf("v%0d_accessErr", i), {31'h0, bus.accessErr}, 32'h1);
        chk($sformatf("v%0d_noReq", i), {31'h0, bus.dmReq}, 32'h0);
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d_errPulse", i), {30'h0, bus.accessErr, bus.dmReq}, 32'h0);
        chk($sformatf("v%0d_rdKeep", i), bus.rdData, last_rd);
      end else begin
        chk($sformatf("v%0d_wait_req_we", i), {30'h0, bus.dmReq, bus.dmWe}, {30'h0, 1'b1, v[i].wr});
        chk($sformatf("v%0d_dmAddr", i), bus.dmAddr, v[i].da);
        chk($sformatf("v%0d_dmBe", i), {28'h0, bus.dmBe}, {28'h0, v[i].be});
        chk($sformatf("v%0d_dmWdata", i), bus.dmWdata, v[i].dw);
        chk($sformatf("v%0d_wait_stall", i), {31'h0, bus.stall}, 32'h1);
        bus.dmAck = 1'b1; bus.dmRdata = v[i].rdat;
        @(negedge clk);
        if (v[i].rd) last_rd = v[i].rv;
        chk($sformatf("v%0d_rdData", i), bus.rdData, last_rd);
        chk($sformatf("v%0d_done", i), {30'h0, bus.stall, bus.dmReq}, 32'h0);
        idle_inputs();
        bus.dmAck = 1'b1;
        @(negedge clk);
        chk($sformatf("v%0d_idleAck", i), {30'h0, bus.dmReq, bus.stall}, 32'h0);
        bus.dmAck = 1'b0;
      end
    end
    drive(1'b0, 1'b1, 2'd0, 1'b0, 32'h400, 32'h13579BDF);
    #1;
    st = int'(bus.stall);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      st += int'(bus.stall);
      bus.addr = 32'h555; bus.wrData = 32'h0; bus.memDataSize = 2'd2;
      chk($sformatf("dly_stable%0d", k), {bus.dmAddr[31:4], bus.dmBe}, {28'h0000040, 4'b1111});
      chk($sformatf("dly_wdata%0d", k), bus.dmWdata, 32'h13579BDF);
      chk($sformatf("dly_req%0d", k), {30'h0, bus.dmReq, bus.dmWe}, 32'h3);
      if (k == 3) bus.dmAck = 1'b1;
    end
    @(negedge clk);
    chk("dly_done_stall", {31'h0, bus.stall}, 32'h0);
    chk("dly_stall_cycles", st, 5);
    chk("dly_rdKeep", bus.rdData, last_rd);
    idle_inputs();
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
    waits = 0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus.busErr) seen = 1'b1;
      else if (bus.dmReq) waits++;
    end
    chk("to_seen", {31'h0, seen}, 32'h1);
    chk("to_wait_cycles", waits, 16);
    chk("to_rdData", bus.rdData, 32'h0);
    chk("to_done", {30'h0, bus.stall, bus.dmReq}, 32'h0);
    idle_inputs();
    @(negedge clk);
    chk("to_pulse", {31'h0, bus.busErr}, 32'h0);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("rst_wait_req", {31'h0, bus.dmReq}, 32'h1);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_req_drop", {30'h0, bus.dmReq, bus.stall}, 32'h0);
    bus.dmAck = 1'b1; bus.dmRdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_after_req", {29'h0, bus.dmReq, bus.stall, bus.busErr}, 32'h0);
    chk("rst_after_rd", bus.rdData, 32'h0);
    chk("rst_after_be", {28'h0, bus.dmBe}, 32'h0);
    bus.dmAck = 1'b0;
    @(negedge clk);
    chk("rst_late_ack", {31'h0, bus.dmReq}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
